// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request/response bundle for sram_controller.
interface sram_controller_if;
  logic rd_en, wr_en, ready;
  logic [31:0] address, write_data, read_data;
  modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
  modport slave (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: MEM-stage data memory over a 16-bit async SRAM, two half-accesses per word.
// Optional SRAM_READ_REUSE_EN: a repeat read of the last read word completes without an SRAM cycle.
module sram_controller #(
  parameter int ADDR_W = 18,
  parameter int WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic clk,
  input  logic rst,
  sram_controller_if.slave bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic SRAM_WE_N
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int WW = ADDR_W - 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] HOLD = CW'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] word, word_in;
  logic [31:0] wdata;
  logic [15:0] lo_buf, dq_out;
  logic is_wr, dq_oe, req, hit, last;
  assign req = bus.rd_en | bus.wr_en;
  assign word_in = WW'((bus.address - BASE_ADDR) >> 2);
  assign last = cnt == LAST;
  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;
  assign bus.ready = !rst || state == DONE || (state == IDLE && !(req && !hit));
`ifdef SRAM_READ_REUSE_EN
  logic valid;
  logic [WW-1:0] last_word;
  assign hit = bus.rd_en && !bus.wr_en && valid && word_in == last_word;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      last_word <= '0;
    end else if (state == IDLE && bus.wr_en) begin
      valid <= 1'b0;
    end else if (state == HIGH && last && !is_wr) begin
      valid <= 1'b1;
      last_word <= word;
    end
  end
`else
  assign hit = 1'b0;
`endif
  // The last cycle of each half keeps address/data on the pins with WE_N high for hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
      wdata <= '0;
      is_wr <= 1'b0;
      lo_buf <= '0;
      bus.read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe <= 1'b0;
      dq_out <= '0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          state <= LOW;
          cnt <= '0;
          word <= word_in;
          wdata <= bus.write_data;
          is_wr <= bus.wr_en;
          SRAM_ADDR <= {word_in, 1'b0};
          dq_out <= bus.write_data[15:0];
          dq_oe <= bus.wr_en;
          SRAM_WE_N <= !bus.wr_en;
        end
        LOW, HIGH: if (last) begin
          cnt <= '0;
          if (state == LOW) begin
            state <= HIGH;
            lo_buf <= SRAM_DQ;
            SRAM_ADDR <= {word, 1'b1};
            dq_out <= wdata[31:16];
            SRAM_WE_N <= !is_wr;
          end else begin
            state <= DONE;
            dq_oe <= 1'b0;
            SRAM_WE_N <= 1'b1;
            if (!is_wr) bus.read_data <= {SRAM_DQ, lo_buf};
          end
        end else begin
          cnt <= cnt + CW'(1);
          SRAM_WE_N <= !is_wr || cnt == HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller with a transaction-level timeline model.
module tb_sram_controller;
  localparam int W = 2;
  localparam int LAST_AGE = 2 * (W + 1);
  localparam int DONE_AGE = LAST_AGE + 1;
`ifdef SRAM_READ_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sram_controller_if bus();
  logic [17:0] sram_addr;
  wire [15:0] sram_dq;
  logic sram_we_n;
  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n)
  );
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // SRAM device: preloaded with zero, writes on clock edges that see WE_N low.
  logic [15:0] mem [0:63] = '{default: 16'h0000};
  logic drv;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sram_dq[i]);
  end
  assign sram_dq = drv ? mem[sram_addr[5:0]] : 16'bz;
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
  // Model: age = cycles since the request was accepted; -1 when idle.
  int age = -1;
  logic op_wr = 1'b0;
  logic [16:0] m_word = '0;
  logic [31:0] m_data = '0;
  logic [31:0] exp_rd = '0;
  logic m_valid = 1'b0;
  logic [16:0] m_last = '0;
  logic [31:0] gold [int];
  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) / 4);
  endfunction
  logic hit_m;
  assign hit_m = REUSE && bus.rd_en && !bus.wr_en && m_valid && word_of(bus.address) == m_last;
  assign drv = age >= 1 && age <= LAST_AGE && !op_wr;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= -1;
      exp_rd <= '0;
      m_valid <= 1'b0;
    end else if (age == -1) begin
      if ((bus.rd_en || bus.wr_en) && !hit_m) begin
        age <= 1;
        op_wr <= bus.wr_en;
        m_word <= word_of(bus.address);
        m_data <= bus.write_data;
        if (bus.wr_en) begin
          gold[int'(word_of(bus.address))] = bus.write_data;
          m_valid <= 1'b0;
        end
      end
    end else begin
      age <= age == DONE_AGE ? -1 : age + 1;
      if (age == LAST_AGE && !op_wr) begin
        exp_rd <= gold.exists(int'(m_word)) ? gold[int'(m_word)] : 32'h0;
        m_valid <= 1'b1;
        m_last <= m_word;
      end
    end
  end
  logic exp_ready;
  int half, pos;
  always @(negedge clk) begin
    exp_ready = !rst || (age == -1 ? !((bus.rd_en || bus.wr_en) && !hit_m) : age == DONE_AGE);
    if (!rst || age < 1 || age > LAST_AGE) begin
      check("we_n_idle", 32'(sram_we_n), 32'd1);
      check("dq_released", 32'(sram_dq), 32'hFFFF);
    end else begin
      half = (age - 1) / (W + 1);
      pos = (age - 1) % (W + 1);
      check("sram_addr", 32'(sram_addr), 32'({m_word, 1'(half)}));
      check("we_n", 32'(sram_we_n), 32'(!(op_wr && pos < W)));
      if (op_wr) check("dq_write", 32'(sram_dq), 32'(half == 1 ? m_data[31:16] : m_data[15:0]));
    end
    check("ready", 32'(bus.ready), 32'(exp_ready));
    check("read_data", bus.read_data, exp_rd);
  end
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lows, output int wes);
    lows = 0;
    wes = 0;
    @(posedge clk);
    #1;
    bus.rd_en = r;
    bus.wr_en = w;
    bus.address = a;
    bus.write_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) wes++;
      if (bus.ready) break;
      lows++;
    end
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask
  initial begin
    int lows, wes;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.address = 32'd1036;
    bus.write_data = 32'h1111_2222;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq", 32'(sram_dq), 32'hFFFF);
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, lows, wes);
    check("wr_stall", 32'(lows), 32'd7);
    check("wr_we_cycles", 32'(wes), 32'd4);
    check("mem2", 32'(mem[2]), 32'hBEEF);
    check("mem3", 32'(mem[3]), 32'hDEAD);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lows, wes);
    check("rd_stall", 32'(lows), 32'd7);
    check("rd_data", bus.read_data, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lows, wes);
    check("rd_again_stall", 32'(lows), REUSE ? 32'd0 : 32'd7);
    check("rd_again_data", bus.read_data, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    check("rd_data_hold", bus.read_data, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, lows, wes);
    check("wr2_stall", 32'(lows), 32'd7);
    check("wr2_data_kept", bus.read_data, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lows, wes);
    check("rd_after_wr_stall", 32'(lows), 32'd7);
    access(1'b1, 1'b0, 32'd1040, 32'h0, lows, wes);
    check("rd_1040_data", bus.read_data, 32'hCAFE_F00D);
    access(1'b1, 1'b1, 32'd1032, 32'h1234_5678, lows, wes);
    check("both_stall", 32'(lows), 32'd7);
    check("both_we_cycles", 32'(wes), 32'd4);
    check("mem4", 32'(mem[4]), 32'h5678);
    check("mem5", 32'(mem[5]), 32'h1234);
    check("both_data_kept", bus.read_data, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b1;
    bus.address = 32'd1036;
    bus.write_data = 32'hAAAA_5555;
    repeat (W + 2) @(posedge clk);
    #3;
    check("high_we_n", 32'(sram_we_n), 32'd0);
    check("high_dq", 32'(sram_dq), 32'hAAAA);
    rst = 1'b0;
    #1;
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_dq", 32'(sram_dq), 32'hFFFF);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mem6", 32'(mem[6]), 32'h5555);
    check("mem7", 32'(mem[7]), 32'h0000);
    check("post_rst_data", bus.read_data, 32'h0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lows, wes);
    check("post_rst_rd_stall", 32'(lows), 32'd7);
    check("post_rst_rd_data", bus.read_data, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
